// File: rtl/data_mem_ring.sv
// Multi-channel circular sample-history memory with age-addressed reads and per-channel zero-run flags.
// Optional per-channel flush port enabled by defining DATA_MEM_FLUSH_EN.
module data_mem_ring #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 256,
    parameter int CHANNELS = 2,
    parameter int ZERO_RUN = 800,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int ZW = $clog2(ZERO_RUN + 1)
) (
    input  logic                Sclk,
    input  logic                Reset,
    input  logic                Frame,
    input  logic                input_ready,
    input  logic [CW-1:0]       wr_chan,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                rd_req,
    input  logic [CW-1:0]       rd_chan,
    input  logic [AW-1:0]       rd_offset,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   data_stored,
    output logic [CHANNELS-1:0] allzeros,
    output logic                wr_err
`ifdef DATA_MEM_FLUSH_EN
    ,
    input  logic [CHANNELS-1:0] flush
`endif
);

    localparam logic [CW:0]   CH_LIM = (CW + 1)'(CHANNELS);
    localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
    localparam logic [ZW-1:0] ZMAX   = ZW'(ZERO_RUN);

    logic [DATA_W-1:0] mem_q  [CHANNELS][DEPTH];
    logic [AW-1:0]     wptr_q [CHANNELS];
    logic [AW-1:0]     wptr_d [CHANNELS];
    logic [AW:0]       fill_q [CHANNELS];
    logic [AW:0]       fill_d [CHANNELS];
    logic [ZW-1:0]     zcnt_q [CHANNELS];
    logic [ZW-1:0]     zcnt_d [CHANNELS];
    logic [AW-1:0]     rd_addr [CHANNELS];
    logic [CHANNELS-1:0] wr_en;

    logic              wr_chan_ok;
    logic [DATA_W-1:0] rd_word;
    logic              rd_valid_q;
    logic [DATA_W-1:0] data_stored_q;
    logic              wr_err_q;

    assign wr_chan_ok = ({1'b0, wr_chan} < CH_LIM);

    // Per-channel next state: ring pointer, fill level and saturating zero-run count.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        wptr_d = wptr_q;
        fill_d = fill_q;
        zcnt_d = zcnt_q;
        wr_en  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (input_ready && wr_chan == CW'(c)) begin
                if (Frame) begin
                    wr_en[c]  = 1'b1;
                    wptr_d[c] = wptr_q[c] + AW'(1);
                    if (fill_q[c] != FULL) begin
                        fill_d[c] = fill_q[c] + (AW + 1)'(1);
                    end
                end
                if (data_in == '0) begin
                    if (zcnt_q[c] != ZMAX) begin
                        zcnt_d[c] = zcnt_q[c] + ZW'(1);
                    end
                end else begin
                    zcnt_d[c] = '0;
                end
            end
`ifdef DATA_MEM_FLUSH_EN
            // Flush overrides a same-cycle write; the discarded sample never reaches the array.
            if (flush[c]) begin
                wr_en[c]  = 1'b0;
                wptr_d[c] = '0;
                fill_d[c] = '0;
                zcnt_d[c] = '0;
            end
`endif
        end
    end

    // Age-relative read: offset 0 is the slot just behind the pre-write pointer.
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rd_addr[c] = wptr_q[c] - AW'(1) - rd_offset;
            if (rd_chan == CW'(c) && ({1'b0, rd_offset} < fill_q[c])) begin
                rd_word = mem_q[c][rd_addr[c]];
            end
        end
    end

    // NOTE: the sample array has no reset; the fill count gates every read, so stale words never escape.
    always_ff @(posedge Sclk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_en[c]) begin
                mem_q[c][wptr_q[c]] <= data_in;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Sclk or posedge Reset) begin
        if (Reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr_q[c] <= '0;
                fill_q[c] <= '0;
                zcnt_q[c] <= '0;
            end
            rd_valid_q    <= 1'b0;
            data_stored_q <= '0;
            wr_err_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            fill_q     <= fill_d;
            zcnt_q     <= zcnt_d;
            rd_valid_q <= rd_req;
            wr_err_q   <= input_ready && !wr_chan_ok;
            if (rd_req) begin
                data_stored_q <= rd_word;
            end
        end
    end

    always_comb begin
        allzeros = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            allzeros[c] = (zcnt_q[c] == ZMAX);
        end
    end

    assign rd_valid    = rd_valid_q;
    assign data_stored = data_stored_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_data_mem_ring.sv
// Randomised bench for data_mem_ring against a queue-based history model.
// Three channels are used so that an out-of-range wr_chan is representable.
module tb_data_mem_ring;

    localparam int DATA_W   = 16;
    localparam int DEPTH    = 256;
    localparam int CHANNELS = 3;
    localparam int ZERO_RUN = 800;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                Sclk = 1'b0;
    logic                Reset;
    logic                Frame;
    logic                input_ready;
    logic [CW-1:0]       wr_chan;
    logic [DATA_W-1:0]   data_in;
    logic                rd_req;
    logic [CW-1:0]       rd_chan;
    logic [AW-1:0]       rd_offset;
    logic                rd_valid;
    logic [DATA_W-1:0]   data_stored;
    logic [CHANNELS-1:0] allzeros;
    logic                wr_err;
    logic [CHANNELS-1:0] flush_v = '0;
`ifdef DATA_MEM_FLUSH_EN
    logic [CHANNELS-1:0] flush;
    assign flush = flush_v;
`endif

    data_mem_ring #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .ZERO_RUN(ZERO_RUN)
    ) dut (
        .Sclk(Sclk), .Reset(Reset), .Frame(Frame), .input_ready(input_ready),
        .wr_chan(wr_chan), .data_in(data_in), .rd_req(rd_req), .rd_chan(rd_chan),
        .rd_offset(rd_offset), .rd_valid(rd_valid), .data_stored(data_stored),
        .allzeros(allzeros), .wr_err(wr_err)
`ifdef DATA_MEM_FLUSH_EN
        , .flush(flush)
`endif
    );

    always #5 Sclk = ~Sclk;

    // Reference model: newest-first history per channel plus an unbounded zero-run length.
    logic [DATA_W-1:0] hist [CHANNELS][$];
    int                zrun [CHANNELS];
    logic [DATA_W-1:0] exp_data;
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [CHANNELS-1:0] exp_az();
        logic [CHANNELS-1:0] v = '0;
        for (int c = 0; c < CHANNELS; c++) v[c] = (zrun[c] >= ZERO_RUN);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            hist[c].delete();
            zrun[c] = 0;
        end
        exp_data = '0;
    endtask

    // One clock: drive, predict from pre-edge model, advance model, compare.
    task automatic cycle(input logic ir, input logic fr, input logic [CW-1:0] wc,
                         input logic [DATA_W-1:0] d, input logic rq,
                         input logic [CW-1:0] rc, input logic [AW-1:0] ro);
        logic exp_err;
        input_ready = ir; Frame = fr; wr_chan = wc; data_in = d;
        rd_req = rq; rd_chan = rc; rd_offset = ro;
        if (rq) begin
            if (int'(rc) < CHANNELS && int'(ro) < hist[rc].size()) exp_data = hist[rc][ro];
            else exp_data = '0;
        end
        exp_err = ir && (int'(wc) >= CHANNELS);
        @(posedge Sclk); #1;
        if (ir && int'(wc) < CHANNELS) begin
            if (fr) begin
                hist[wc].push_front(d);
                if (hist[wc].size() > DEPTH) void'(hist[wc].pop_back());
            end
            if (d == '0) zrun[wc]++;
            else zrun[wc] = 0;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (flush_v[c]) begin
                hist[c].delete();
                zrun[c] = 0;
            end
        end
        check("rd_valid", rd_valid, rq);
        check("data_stored", data_stored, exp_data);
        check("wr_err", wr_err, exp_err);
        check("allzeros", allzeros, exp_az());
    endtask

    task automatic wr(input logic [CW-1:0] ch, input logic [DATA_W-1:0] d);
        cycle(1'b1, 1'b1, ch, d, 1'b0, '0, '0);
    endtask

    task automatic rd_expect(input string tag, input logic [CW-1:0] ch,
                             input logic [AW-1:0] off, input logic [DATA_W-1:0] val);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, ch, off);
        check(tag, data_stored, val);
    endtask

    initial begin
        Reset = 1'b1; Frame = 1'b0; input_ready = 1'b0; wr_chan = '0; data_in = '0;
        rd_req = 1'b0; rd_chan = '0; rd_offset = '0;
        model_reset();
        #12 Reset = 1'b0;
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_data", data_stored, '0);
        check("reset_allzeros", allzeros, '0);
        check("reset_wr_err", wr_err, 1'b0);

        // Basic history and zero padding beyond fill.
        wr(0, 16'd1); wr(0, 16'd2); wr(0, 16'd3);
        rd_expect("ch0_off0", 0, 0, 16'd3);
        rd_expect("ch0_off1", 0, 1, 16'd2);
        rd_expect("ch0_off2", 0, 2, 16'd1);
        rd_expect("ch0_off3_pad", 0, 3, 16'd0);

        // Wrap ch1 past DEPTH; ch0 untouched.
        for (int i = 1; i <= DEPTH + 2; i++) wr(1, DATA_W'(i));
        rd_expect("ch1_off0", 1, 0, DATA_W'(DEPTH + 2));
        rd_expect("ch1_off255", 1, AW'(DEPTH - 1), 16'd3);
        rd_expect("ch0_after_ch1", 0, 0, 16'd3);
        rd_expect("ch2_empty", 2, 0, 16'd0);
        rd_expect("ch3_oob_read", 3, 0, 16'd0);

        // Read-before-write where read and write address coincide on a full ring.
        cycle(1'b1, 1'b1, 1, 16'h0777, 1'b1, 1, AW'(DEPTH - 1));
        check("rbw_full", data_stored, 16'd3);
        rd_expect("ch1_new", 1, 0, 16'h0777);

        // Frame low stores nothing; out-of-range channel flags wr_err.
        cycle(1'b1, 1'b0, 0, 16'h00AA, 1'b0, '0, '0);
        rd_expect("frame_low", 0, 0, 16'd3);
        cycle(1'b1, 1'b1, 3, 16'h00BB, 1'b0, '0, '0);
        check("wr_err_pulse", wr_err, 1'b1);
        cycle(1'b0, 1'b0, 0, '0, 1'b0, '0, '0);
        check("wr_err_clear", wr_err, 1'b0);
        rd_expect("oob_nostore", 0, 0, 16'd3);

        // Zero-run threshold and saturation.
        for (int i = 0; i < ZERO_RUN - 1; i++) wr(0, '0);
        check("az_799", allzeros[0], 1'b0);
        wr(0, '0);
        check("az_800", allzeros[0], 1'b1);
        for (int i = 0; i < 1000; i++) wr(0, '0);
        check("az_1800", allzeros[0], 1'b1);
        wr(0, 16'h0001);
        check("az_clear", allzeros, '0);

        // Same-cycle write and read on one channel.
        wr(0, 16'd5);
        cycle(1'b1, 1'b1, 0, 16'd9, 1'b1, 0, 0);
        check("same_cycle_old", data_stored, 16'd5);
        rd_expect("same_cycle_new", 0, 0, 16'd9);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [AW-1:0] off;
            off = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                  CW'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 0) ? '0 : DATA_W'($urandom),
                  1'($urandom_range(0, 1)), CW'($urandom_range(0, 3)), off);
        end

        // Reset while a read is outstanding and a zero flag is set.
        for (int i = 0; i < 10; i++) wr(0, DATA_W'(i + 100));
        for (int i = 0; i < ZERO_RUN; i++) wr(1, '0);
        check("az_ch1_set", allzeros[1], 1'b1);
        cycle(1'b0, 1'b0, 0, '0, 1'b1, 0, 0);
        input_ready = 1'b0; rd_req = 1'b1; rd_chan = '0; rd_offset = '0;
        #2 Reset = 1'b1;
        #1;
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_allzeros", allzeros, '0);
        check("rst_data", data_stored, '0);
        @(posedge Sclk); #1;
        check("rst_inflight", rd_valid, 1'b0);
        Reset = 1'b0;
        model_reset();
        rd_expect("post_rst", 0, 0, 16'd0);

`ifdef DATA_MEM_FLUSH_EN
        wr(0, 16'd21); wr(1, 16'd31);
        flush_v = 3'b001;
        cycle(1'b1, 1'b1, 0, 16'd22, 1'b1, 0, 0);
        check("flush_preread", data_stored, 16'd21);
        flush_v = '0;
        rd_expect("flush_ch0", 0, 0, 16'd0);
        rd_expect("flush_ch1", 1, 0, 16'd31);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
